// File: rtl/uc_seq.sv
// Microcoded-style control sequencer: decodes the fetched opcode into datapath
// control lines, tracks return-stack depth, and traps into HALT on faults.
module uc_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        z,
  output logic        s_inc,
  output logic        s_inm,
  output logic        s_rre,
  output logic        s_ret,
  output logic        we3,
  output logic        wez,
  output logic [2:0]  op,
  output logic        pc_en,
  output logic        halted,
  output logic        err,
  output logic [15:0] icount
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [5:0] OP_J    = 6'b110000;
  localparam logic [5:0] OP_JZ   = 6'b110001;
  localparam logic [5:0] OP_JNZ  = 6'b110010;
  localparam logic [5:0] OP_JAL  = 6'b110011;
  localparam logic [5:0] OP_RET  = 6'b110100;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [2:0] DEPTH_MAX = 3'd4;

  state_t      state_reg, state_next;
  logic [2:0]  depth_reg;
  logic        err_reg;
  logic [15:0] icount_reg;

  logic is_alu, is_li, is_jal, is_ret, is_halt, is_illegal;
  logic trap, err_set;

  always_comb begin
    is_alu     = ~opcode[5];
    is_li      = (opcode[5:4] == 2'b10);
    is_jal     = (opcode == OP_JAL);
    is_ret     = (opcode == OP_RET);
    is_halt    = (opcode == OP_HALT);
    is_illegal = (opcode[5:4] == 2'b11) &&
                 !(opcode inside {OP_J, OP_JZ, OP_JNZ, OP_JAL, OP_RET, OP_HALT});
    trap       = is_halt || is_illegal ||
                 (is_jal && depth_reg == DEPTH_MAX) ||
                 (is_ret && depth_reg == 3'd0);
  end

  always_comb begin
    s_inc      = 1'b0;
    s_inm      = 1'b0;
    s_rre      = 1'b0;
    s_ret      = 1'b0;
    we3        = 1'b0;
    wez        = 1'b0;
    op         = 3'b000;
    pc_en      = 1'b0;
    err_set    = 1'b0;
    state_next = state_reg;

    case (state_reg)
      RUN: begin
        if (is_alu) begin
          we3   = 1'b1;
          wez   = 1'b1;
          s_inc = 1'b1;
          op    = opcode[4:2];
        end else if (is_li) begin
          we3   = 1'b1;
          s_inm = 1'b1;
          s_inc = 1'b1;
        end else begin
          case (opcode)
            OP_JZ:   s_inc = ~z;
            OP_JNZ:  s_inc = z;
            OP_JAL:  s_rre = 1'b1;
            OP_RET:  s_ret = 1'b1;
            default: s_inc = 1'b0;
          endcase
        end

        if (trap) begin
          // The faulting/halting instruction must not commit anything.
          s_inc      = 1'b1;
          s_rre      = 1'b0;
          s_ret      = 1'b0;
          we3        = 1'b0;
          wez        = 1'b0;
          op         = 3'b000;
          err_set    = ~is_halt;
          state_next = HALT;
        end else begin
          pc_en = 1'b1;
        end
      end
      HALT: begin
        s_inc = 1'b1;
      end
      default: state_next = RUN;
    endcase

    if (reset) begin
      pc_en = 1'b0;
      we3   = 1'b0;
      wez   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= RUN;
      depth_reg  <= 3'd0;
      err_reg    <= 1'b0;
      icount_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (pc_en) begin
        icount_reg <= icount_reg + 16'd1;
        if (is_jal)
          depth_reg <= depth_reg + 3'd1;
        else if (is_ret)
          depth_reg <= depth_reg - 3'd1;
      end
      if (err_set)
        err_reg <= 1'b1;
    end
  end

  assign halted = (state_reg == HALT);
  assign err    = err_reg;
  assign icount = icount_reg;

endmodule

// File: tb/tb_uc_seq.sv
// Directed self-checking bench for uc_seq: decode, jumps, stack faults,
// halt/reset behaviour and instruction-counter wrap.
module tb_uc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        z;
  logic        s_inc, s_inm, s_rre, s_ret, we3, wez;
  logic [2:0]  op;
  logic        pc_en, halted, err;
  logic [15:0] icount;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] LI   = 6'b100000;
  localparam logic [5:0] ALU2 = 6'b001000;
  localparam logic [5:0] JZ   = 6'b110001;
  localparam logic [5:0] JNZ  = 6'b110010;
  localparam logic [5:0] JAL  = 6'b110011;
  localparam logic [5:0] RET  = 6'b110100;
  localparam logic [5:0] HLT  = 6'b111111;
  localparam logic [5:0] ILL  = 6'b110101;

  uc_seq dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .z      (z),
    .s_inc  (s_inc),
    .s_inm  (s_inm),
    .s_rre  (s_rre),
    .s_ret  (s_ret),
    .we3    (we3),
    .wez    (wez),
    .op     (op),
    .pc_en  (pc_en),
    .halted (halted),
    .err    (err),
    .icount (icount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic apply(input logic [5:0] o, input logic zz);
    opcode = o;
    z      = zz;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(LI, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    opcode = LI;
    z      = 1'b0;
    #1;
    chk("rst_pc_en", {15'd0, pc_en}, 16'd0);
    chk("rst_we3", {15'd0, we3}, 16'd0);
    chk("rst_wez", {15'd0, wez}, 16'd0);
    tick();
    chk("rst_icount", icount, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    reset = 1'b0;

    // li then ALU op=010
    apply(LI, 1'b0);
    chk("li_we3", {15'd0, we3}, 16'd1);
    chk("li_s_inm", {15'd0, s_inm}, 16'd1);
    chk("li_s_inc", {15'd0, s_inc}, 16'd1);
    chk("li_wez", {15'd0, wez}, 16'd0);
    chk("li_pc_en", {15'd0, pc_en}, 16'd1);
    tick();
    apply(ALU2, 1'b0);
    chk("alu_we3", {15'd0, we3}, 16'd1);
    chk("alu_wez", {15'd0, wez}, 16'd1);
    chk("alu_op", {13'd0, op}, 16'd2);
    chk("alu_s_inc", {15'd0, s_inc}, 16'd1);
    chk("alu_s_inm", {15'd0, s_inm}, 16'd0);
    tick();
    chk("icount_2", icount, 16'd2);

    // jnz / jz with both z values
    apply(JNZ, 1'b0);
    chk("jnz_z0_s_inc", {15'd0, s_inc}, 16'd0);
    chk("jnz_we3", {15'd0, we3}, 16'd0);
    chk("jnz_op", {13'd0, op}, 16'd0);
    tick();
    apply(JNZ, 1'b1);
    chk("jnz_z1_s_inc", {15'd0, s_inc}, 16'd1);
    tick();
    chk("icount_4", icount, 16'd4);
    apply(JZ, 1'b1);
    chk("jz_z1_s_inc", {15'd0, s_inc}, 16'd0);
    apply(JZ, 1'b0);
    chk("jz_z0_s_inc", {15'd0, s_inc}, 16'd1);
    tick();
    chk("icount_5", icount, 16'd5);

    // five jal from reset: fifth overflows the stack
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(JAL, 1'b0);
      chk("jal_s_rre", {15'd0, s_rre}, 16'd1);
      chk("jal_s_inc", {15'd0, s_inc}, 16'd0);
      chk("jal_pc_en", {15'd0, pc_en}, 16'd1);
      tick();
      chk("jal_depth", {13'd0, dut.depth_reg}, 16'(i + 1));
      chk("jal_halted", {15'd0, halted}, 16'd0);
    end
    apply(JAL, 1'b0);
    chk("jal5_pc_en", {15'd0, pc_en}, 16'd0);
    chk("jal5_s_rre", {15'd0, s_rre}, 16'd0);
    tick();
    chk("jal5_err", {15'd0, err}, 16'd1);
    chk("jal5_halted", {15'd0, halted}, 16'd1);
    chk("jal5_icount", icount, 16'd4);
    chk("jal5_depth", {13'd0, dut.depth_reg}, 16'd4);
    apply(LI, 1'b0);
    chk("halt_pc_en", {15'd0, pc_en}, 16'd0);
    chk("halt_we3", {15'd0, we3}, 16'd0);
    chk("halt_s_inc", {15'd0, s_inc}, 16'd1);
    chk("halt_s_inm", {15'd0, s_inm}, 16'd0);
    do_reset();
    chk("midsub_depth", {13'd0, dut.depth_reg}, 16'd0);
    chk("midsub_err", {15'd0, err}, 16'd0);

    // ret from empty stack
    apply(RET, 1'b0);
    chk("ret0_s_ret", {15'd0, s_ret}, 16'd0);
    chk("ret0_pc_en", {15'd0, pc_en}, 16'd0);
    tick();
    chk("ret0_err", {15'd0, err}, 16'd1);
    chk("ret0_halted", {15'd0, halted}, 16'd1);
    apply(ALU2, 1'b0);
    chk("ret0_alu_we3", {15'd0, we3}, 16'd0);
    chk("ret0_alu_wez", {15'd0, wez}, 16'd0);
    chk("ret0_alu_op", {13'd0, op}, 16'd0);
    tick();
    apply(JAL, 1'b0);
    chk("ret0_jal_s_rre", {15'd0, s_rre}, 16'd0);
    tick();
    chk("ret0_icount", icount, 16'd0);
    chk("ret0_still_halt", {15'd0, halted}, 16'd1);

    // balanced jal/ret
    do_reset();
    apply(JAL, 1'b0);
    tick();
    apply(RET, 1'b0);
    chk("ret1_s_ret", {15'd0, s_ret}, 16'd1);
    chk("ret1_pc_en", {15'd0, pc_en}, 16'd1);
    chk("ret1_s_inc", {15'd0, s_inc}, 16'd0);
    tick();
    chk("ret1_depth", {13'd0, dut.depth_reg}, 16'd0);
    chk("ret1_icount", icount, 16'd2);
    chk("ret1_err", {15'd0, err}, 16'd0);

    // halt after 3 li, then reset recovery
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(LI, 1'b0);
      tick();
    end
    apply(HLT, 1'b0);
    chk("hlt_pc_en", {15'd0, pc_en}, 16'd0);
    tick();
    chk("hlt_halted", {15'd0, halted}, 16'd1);
    chk("hlt_err", {15'd0, err}, 16'd0);
    chk("hlt_icount", icount, 16'd3);
    do_reset();
    chk("hrst_halted", {15'd0, halted}, 16'd0);
    chk("hrst_icount", icount, 16'd0);
    chk("hrst_depth", {13'd0, dut.depth_reg}, 16'd0);
    apply(LI, 1'b0);
    chk("hrst_li_we3", {15'd0, we3}, 16'd1);
    chk("hrst_li_pc_en", {15'd0, pc_en}, 16'd1);

    // illegal opcode
    do_reset();
    apply(ILL, 1'b0);
    chk("ill_pc_en", {15'd0, pc_en}, 16'd0);
    tick();
    chk("ill_err", {15'd0, err}, 16'd1);
    chk("ill_halted", {15'd0, halted}, 16'd1);

    // icount wrap
    do_reset();
    apply(LI, 1'b0);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", icount, 16'hFFFF);
    tick();
    chk("wrap_0000", icount, 16'h0000);
    tick();
    chk("wrap_0001", icount, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uc_seq.md
UC_SEQ -- requirements
Module: uc_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-003 The block SHALL have the port opcode, input, 6 bits: opcode field of the instruction currently fetched by the datapath.
REQ-004 The block SHALL have the port z, input, 1 bit: registered zero flag from the datapath.
REQ-005 The block SHALL have the ports s_inc, s_inm, s_rre, s_ret, we3 and wez, outputs, 1 bit each: datapath control lines.
REQ-006 The block SHALL have the port op, output, 3 bits: ALU operation select.
REQ-007 The block SHALL have the port pc_en, output, 1 bit: PC write enable; 0 freezes the PC.
REQ-008 The block SHALL have the port halted, output, 1 bit: 1 while the FSM is in HALT.
REQ-009 The block SHALL have the port err, output, 1 bit: sticky fault flag (stack overflow/underflow, illegal opcode).
REQ-010 The block SHALL have the port icount, output, 16 bits: count of retired instructions.

Function
REQ-011 Opcode decode SHALL be: 0oooxx = ALU op with op=opcode[4:2]; 10xxxx = li; 110000 = j; 110001 = jz; 110010 = jnz; 110011 = jal; 110100 = ret; 111111 = halt; any other 11xxxx = illegal.
REQ-012 The controls for ALU ops SHALL be: we3=1, wez=1, s_inm=0, s_inc=1, op=opcode[4:2].
REQ-013 The controls for li SHALL be: we3=1, s_inm=1, op=000, wez=0, s_inc=1.
REQ-014 The controls for j SHALL be: s_inc=0, with all write enables 0.
REQ-015 The controls for jz SHALL be: s_inc = ~z; jnz SHALL be: s_inc = z.
REQ-016 The controls for jal SHALL be: s_rre=1, s_inc=0; ret SHALL be: s_ret=1, s_inc=0.
REQ-017 Any control not listed for an opcode SHALL be 0, and op SHALL be 000 for non-ALU opcodes.
REQ-018 The FSM SHALL have the states RUN and HALT.
REQ-019 In RUN, controls SHALL follow REQ-012..REQ-017 combinationally from opcode, and pc_en SHALL be 1.
REQ-020 RUN SHALL transition to HALT at the clock edge on which opcode is halt, illegal, jal with depth=4, or ret with depth=0.
REQ-021 Every other RUN cycle SHALL stay in RUN.
REQ-022 In HALT, pc_en, we3, wez, s_rre and s_ret SHALL be 0, s_inc SHALL be 1 (don't-care, PC frozen), and op SHALL be 000.
REQ-023 HALT SHALL be left only by reset.
REQ-024 The cycle that triggers HALT SHALL itself be suppressed: pc_en=0 and all write enables 0, so no register, z or PC update occurs.
REQ-025 A 3-bit depth counter SHALL track the datapath return stack: +1 on a retired jal, -1 on a retired ret, range 0..4.
REQ-026 A jal with depth=4 or a ret with depth=0 SHALL set err=1 and SHALL leave depth unchanged.
REQ-027 An illegal opcode SHALL set err=1.
REQ-028 The halt opcode SHALL NOT set err.
REQ-029 err SHALL remain 1 until reset.
REQ-030 icount SHALL increment by 1 on each RUN cycle with pc_en=1 and SHALL wrap from 0xFFFF to 0x0000.
REQ-031 Not-taken and taken jumps SHALL both count as retired for icount.
REQ-032 halted SHALL be a registered output: 1 from the edge that enters HALT.

Reset
REQ-033 On a rising edge with reset=1, the block SHALL set: state=RUN, depth=0, err=0, icount=0, halted=0.
REQ-034 While reset=1, pc_en, we3 and wez SHALL be forced to 0 regardless of opcode.
REQ-035 Reset asserted mid-subroutine (depth>0) or while in HALT SHALL return the block to the full reset state at the next edge.
REQ-036 In the first cycle after reset deasserts, the block SHALL decode opcode normally in RUN.

Verification
REQ-037 The bench SHALL apply opcode 100000 (li) then 001000 (ALU op=010) -> li cycle: we3=1, s_inm=1, s_inc=1, wez=0; ALU cycle: we3=1, wez=1, op=010, s_inc=1; icount=2 afterwards.
REQ-038 The bench SHALL apply jnz (110010) with z=0 then with z=1 -> first cycle: s_inc=0; second cycle: s_inc=1; icount advances by 2.
REQ-039 The bench SHALL apply 5 consecutive jal (110011) from reset -> depth 1..4, s_rre=1 on the first four; on the fifth: pc_en=0, err=1, halted=1 next edge; icount=4.
REQ-040 The bench SHALL apply ret (110100) from reset -> s_ret forced 0, pc_en=0, err=1, halted=1; then subsequent opcodes -> outputs stay halted, icount=0.
REQ-041 The bench SHALL apply halt (111111) after 3 li -> halted=1, err=0, icount=3; then assert reset 1 cycle -> halted=0, icount=0, depth=0, li decodes normally next cycle.
REQ-042 The bench SHALL preload icount near wrap by running 65535 li, then 2 more -> icount reads 0xFFFF, then 0x0000, then 0x0001.
